cover_toggle_drain: RTL
=======================

Name: cover_toggle_drain

Overview:
- Hardware consumer for toggle-coverage hit vectors; the receiving end of the per-bit cover-valid interface.
- Replaces per-bit simulation callbacks with a single ready/valid stream of global cover indices.
- Each distinct point is reported once: hits are kept sticky, deduplicated, and drained lowest-bit-first into one registered output slot.
- Sits between the per-module toggle-cover instrumentation and a coverage upload/trace sink.

Parameters:
- WIDTH, 29, number of cover points (bits of hit vector) handled by this instance.
- COVER_INDEX, 0, global index of bit 0; bit i reports COVER_INDEX+i.
- COVER_TOTAL, 10906, total cover points in design; used for an elaboration check that COVER_INDEX+WIDTH <= COVER_TOTAL.
- IDX_W, 64, width of emitted index (matches longint cover index).

Ports:
- clock  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- valid  in  WIDTH  per-point hit strobes, sampled every cycle.
- clear  in  1  synchronous pulse: forget all recorded coverage.
- out_valid  out  1  output slot holds an unreported index.
- out_ready  in  1  sink accepts; fire = out_valid & out_ready.
- out_index  out  IDX_W  global cover index (COVER_INDEX + bit).
- covered_count  out  clog2(WIDTH+1)  number of distinct points accepted by sink.
- all_covered  out  1  every point has been loaded into the slot since last reset/clear.

Behaviour:
- Reset (async): pending=0, reported=0, slot empty, out_valid=0, out_index=0, covered_count=0, all_covered=0, state=EMPTY.
- Capture, each edge with reset low and clear low: pending <= (pending | valid) & ~reported & ~load_mask.
  - load_mask is the bit loaded into the slot on that same edge.
- Hits on already-reported bits are dropped. Repeated hits before drain collapse into one.
- Selection: lowest set bit of the registered pending vector. Incoming valid is not bypassed.
- Latency: valid[i] high before edge T sets pending after T. With the slot free, out_valid/out_index are valid after edge T+1.
- States:
  - EMPTY: out_valid=0. If pending != 0, load the lowest bit, set reported[bit], clear pending[bit]; go FULL.
  - FULL: out_valid=1, out_index held stable until fire.
    - On fire: covered_count++.
    - If pending (excluding nothing newly loaded) != 0, load the next lowest bit on the same edge and stay FULL (back-to-back, 1 index/cycle).
    - Otherwise go EMPTY.
    - No fire: hold; pending keeps accumulating.
- all_covered = &reported, registered alongside reported. Rises on the edge the last bit is loaded.
- clear (priority over capture):
  - pending <= 0, reported <= 0, covered_count <= 0 (a same-cycle fire does not increment).
  - valid in the clear cycle is ignored; all_covered <= 0.
  - An occupied slot is not dropped: it stays FULL until fired, but no new load happens on the clear edge.
  - The slot index is not re-marked reported, so it may be reported again after clear.
- Counter never exceeds WIDTH, because each bit is loaded at most once per reset/clear epoch.
- out_index = COVER_INDEX + bit, zero-extended to IDX_W. Arithmetic is IDX_W wide with no wrap (elaboration check guarantees it).
- Reset asserted mid-stream: immediate return to reset values. Any in-flight index is lost by design.

Decomposition:
- Package cover_drain_pkg:
  - state enum {EMPTY, FULL};
  - cover_idx_t (IDX_W-bit);
  - function computing the count width.
- One sub-module, cover_lsb_pick: parameterized WIDTH lowest-set-bit encoder that outputs found and bit index.

Test Plan:
- WIDTH=29, COVER_INDEX=100, out_ready=1. Pulse valid=29'h0000_0005 one cycle -> out_index 100 two cycles later, then 102 next cycle; covered_count=2; out_valid then low.
- Pulse bit 3 three times over 5 cycles with out_ready=1 -> exactly one 103 emitted; covered_count=1.
- out_ready=0, pulse bits 7 and 4 -> out_valid held with 104 stable for 10 cycles. Raise out_ready -> 104 then 107 on consecutive cycles.
- valid=all ones for one cycle, out_ready=1 -> indices 100..128 in 29 consecutive cycles. covered_count=29; all_covered=1 after the 29th load.
- Slot FULL with 105, pending bit 9. Assert clear while out_ready=0 -> 105 held; after fire, covered_count=0, no 109 emitted. Re-hit bit 5 -> 105 emitted again; count=1.
- Assert reset asynchronously mid-drain (between edges) -> out_valid, covered_count, all_covered go 0 immediately, before the next clock edge.

Source files
------------

// File: rtl/cover_drain_pkg.sv
// cover_drain_pkg
//   Shared types and helpers for the toggle-coverage drain.
//   state_t     : output slot state (EMPTY / FULL)
//   cover_idx_t : global cover index, matches a 64-bit longint index
//   count_w()   : width of a counter able to hold 0..width
package cover_drain_pkg;

   localparam int IDX_W_DEF = 64;

   typedef logic [IDX_W_DEF-1:0] cover_idx_t;

   typedef enum logic [0:0] {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } state_t;

   function automatic int count_w(input int width);
      return (width < 1) ? 1 : $clog2(width + 1);
   endfunction

endpackage

// File: rtl/cover_lsb_pick.sv
// cover_lsb_pick
//   Lowest-set-bit encoder.
//   vec    in  WIDTH  candidate bits
//   found  out 1      any bit of vec is set
//   idx    out IW     position of the lowest set bit (0 when none)
//   onehot out WIDTH  vec with only its lowest set bit kept
module cover_lsb_pick #(
   parameter int WIDTH = 29,
   parameter int IW    = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
   input  logic [WIDTH-1:0] vec,
   output logic             found,
   output logic [IW-1:0]    idx,
   output logic [WIDTH-1:0] onehot
);

   // Two's-complement trick isolates the lowest set bit.
   assign onehot = vec & (~vec + WIDTH'(1));
   assign found  = |vec;

   // Scan from the top so the last match written is the lowest bit.
   always_comb begin
      idx = '0;
      for (int i = WIDTH - 1; i >= 0; i--) begin
         if (vec[i]) idx = IW'(i);
      end
   end

endmodule

// File: rtl/cover_toggle_drain.sv
// cover_toggle_drain
//   Collects per-point toggle-coverage hit strobes, remembers each point
//   once, and drains newly covered points lowest-bit-first as global
//   cover indices through a single registered ready/valid slot.
//
//   clock          in   1       rising-edge clock
//   reset          in   1       asynchronous, active-high reset
//   valid          in   WIDTH   per-point hit strobes, sampled every edge
//   clear          in   1       synchronous: forget all recorded coverage
//   out_valid      out  1       slot holds an unreported index
//   out_ready      in   1       sink accepts the slot this cycle
//   out_index      out  IDX_W   COVER_INDEX + bit of the slot
//   covered_count  out  CW      distinct points accepted by the sink
//   all_covered    out  1       every point loaded since reset/clear
module cover_toggle_drain
   import cover_drain_pkg::*;
#(
   parameter int          WIDTH       = 29,
   parameter int unsigned COVER_INDEX = 0,
   parameter int unsigned COVER_TOTAL = 10906,
   parameter int          IDX_W       = 64,
   localparam int         CW          = count_w(WIDTH),
   localparam int         IW          = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [WIDTH-1:0] valid,
   input  logic             clear,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [IDX_W-1:0] out_index,
   output logic [CW-1:0]    covered_count,
   output logic             all_covered
);

   // This instance's index range must fit inside the design's cover space,
   // which also guarantees the index addition never wraps.
   if (longint'(COVER_INDEX) + longint'(WIDTH) > longint'(COVER_TOTAL)) begin : g_range_bad
      $error("cover_toggle_drain: COVER_INDEX+WIDTH exceeds COVER_TOTAL");
   end

   state_t           state;
   logic [WIDTH-1:0] pending;
   logic [WIDTH-1:0] reported;
   // Slot content still belongs to the current epoch; a slot carried across
   // a clear is delivered but not counted.
   logic             slot_counted;

   logic             pick_found;
   logic [IW-1:0]    pick_idx;
   logic [WIDTH-1:0] pick_hot;

   logic             fire;
   logic             load;
   logic [WIDTH-1:0] load_mask;

   // Selection looks only at registered pending; incoming hits wait a cycle.
   cover_lsb_pick #(
      .WIDTH (WIDTH),
      .IW    (IW)
   ) u_pick (
      .vec    (pending),
      .found  (pick_found),
      .idx    (pick_idx),
      .onehot (pick_hot)
   );

   assign out_valid = (state == ST_FULL);
   assign fire      = out_valid & out_ready;

   // The slot can take a new index when empty or when it is being emptied
   // on this edge; clear suppresses loading so nothing stale is picked.
   assign load      = ~clear & pick_found & ((state == ST_EMPTY) | fire);
   assign load_mask = load ? pick_hot : '0;

   // Slot state and contents.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state        <= ST_EMPTY;
         out_index    <= '0;
         slot_counted <= 1'b0;
      end else begin
         if (load) begin
            state        <= ST_FULL;
            out_index    <= IDX_W'(COVER_INDEX) + IDX_W'(pick_idx);
            slot_counted <= 1'b1;
         end else begin
            if (fire) state <= ST_EMPTY;
            if (clear) slot_counted <= 1'b0;
         end
      end
   end

   // Sticky hit tracking. A bit loaded on this edge is removed from pending
   // and moved into reported in the same step, so it can never be queued twice.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         pending     <= '0;
         reported    <= '0;
         all_covered <= 1'b0;
      end else if (clear) begin
         pending     <= '0;
         reported    <= '0;
         all_covered <= 1'b0;
      end else begin
         pending     <= (pending | valid) & ~reported & ~load_mask;
         reported    <= reported | load_mask;
         all_covered <= &(reported | load_mask);
      end
   end

   // Accepted-point counter; bounded by WIDTH since each bit loads at most
   // once per epoch and carried-over slots are excluded.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         covered_count <= '0;
      end else if (clear) begin
         covered_count <= '0;
      end else if (fire && slot_counted) begin
         covered_count <= covered_count + CW'(1);
      end
   end

endmodule
